// File: rtl/half_duplex_link.sv
// ---------------------------------------------------------------------------
// half_duplex_link
//
// Endpoint controller for a single-bit bidirectional line that goes through
// a tristate buffer. The controller drives the buffer enable only while it
// transmits. It receives frames from the far end while it is not driving.
// After every transmit it holds a turnaround guard so that both ends never
// drive the line at the same time.
//
// Frame format (UART style): start bit 0, DATA_W data bits LSB first,
// stop bit 1. Every bit lasts BIT_CYC clock cycles.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset
//   tx_valid  transmit request; a byte is accepted when tx_valid & tx_ready
//   tx_data   payload to send, captured on acceptance
//   tx_ready  idle and the synchronized line reads high
//   line_in   line value read back through the buffer (idle = 1)
//   line_out  registered value to drive onto the line
//   line_oe   registered buffer drive enable
//   rx_valid  one-cycle pulse; rx_data is valid in the same cycle
//   rx_data   last good received payload
//   rx_err    one-cycle pulse when a frame ends with a stop bit of 0
//   busy      high whenever the controller is not in IDLE
// ---------------------------------------------------------------------------
module half_duplex_link #(
    parameter int DATA_W  = 8,
    parameter int BIT_CYC = 4,
    parameter int GUARD   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_ready,
    input  logic              line_in,
    output logic              line_out,
    output logic              line_oe,
    output logic              rx_valid,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_err,
    output logic              busy
);

    localparam int CNT_MAX = (BIT_CYC > GUARD) ? BIT_CYC : GUARD;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int BIT_W   = $clog2(DATA_W + 1);

    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(BIT_CYC - 1);
    localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(BIT_CYC / 2 - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD - 1);
    localparam logic [BIT_W-1:0] DATA_LAST  = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        TX_START,
        TX_DATA,
        TX_STOP,
        TURN,
        RX_START,
        RX_DATA,
        RX_STOP
    } state_t;

    state_t            state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic [BIT_W-1:0]  bit_idx, bit_d;
    logic [DATA_W-1:0] tx_sh, tx_sh_d;
    logic [DATA_W-1:0] rx_sh, rx_sh_d;
    logic              pend_valid, pend_valid_d;
    logic              pend_err, pend_err_d;
    logic              sync_1, rs;
    logic              bit_end;

    // Two-flop synchronizer for the line. It resets to the idle level so that
    // leaving reset never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_1 <= 1'b1;
            rs     <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments, so every
            // flop samples values from before the edge and the two-stage chain
            // really is two stages.
            sync_1 <= line_in;
            rs     <= sync_1;
        end
    end

    assign bit_end  = (cnt == BIT_LAST);
    assign tx_ready = (state == IDLE) && rs;
    assign busy     = (state != IDLE);

    always_comb begin
        // NOTE: every signal written here gets a default first. Without it,
        // a path that skips an assignment would infer a latch.
        state_d      = state;
        cnt_d        = cnt + CNT_W'(1);
        bit_d        = bit_idx;
        tx_sh_d      = tx_sh;
        rx_sh_d      = rx_sh;
        pend_valid_d = 1'b0;
        pend_err_d   = 1'b0;

        case (state)
            IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                // Receive has priority over a simultaneous transmit request.
                if (!rs) begin
                    state_d = RX_START;
                end else if (tx_valid) begin
                    state_d = TX_START;
                    tx_sh_d = tx_data;
                end
            end
            TX_START: begin
                if (bit_end) begin
                    state_d = TX_DATA;
                    cnt_d   = '0;
                    bit_d   = '0;
                end
            end
            TX_DATA: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    tx_sh_d = tx_sh >> 1;
                    if (bit_idx == DATA_LAST) state_d = TX_STOP;
                    else                      bit_d   = bit_idx + BIT_W'(1);
                end
            end
            TX_STOP: begin
                if (bit_end) begin
                    state_d = TURN;
                    cnt_d   = '0;
                end
            end
            TURN: begin
                // The echo of our own frame may still be in the synchronizer,
                // so a low rs is ignored here.
                if (cnt == GUARD_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            RX_START: begin
                // Confirm the start bit near its middle. If it is gone, it was a glitch.
                if (cnt == HALF_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rs ? IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    rx_sh_d = DATA_W'({rs, rx_sh} >> 1);
                    if (bit_idx == DATA_LAST) state_d = RX_STOP;
                    else                      bit_d   = bit_idx + BIT_W'(1);
                end
            end
            RX_STOP: begin
                // The result is posted one edge later from pend_* flops.
                if (bit_end) begin
                    cnt_d        = '0;
                    state_d      = IDLE;
                    pend_valid_d = rs;
                    pend_err_d   = !rs;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: every flop, including the rx_data holding register, has a
            // defined reset value. An aborted frame therefore leaves nothing
            // behind, and line_oe drops as soon as rst rises.
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            tx_sh      <= '0;
            rx_sh      <= '0;
            pend_valid <= 1'b0;
            pend_err   <= 1'b0;
            line_oe    <= 1'b0;
            line_out   <= 1'b1;
            rx_valid   <= 1'b0;
            rx_err     <= 1'b0;
            rx_data    <= '0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            bit_idx    <= bit_d;
            tx_sh      <= tx_sh_d;
            rx_sh      <= rx_sh_d;
            pend_valid <= pend_valid_d;
            pend_err   <= pend_err_d;
            // The line outputs are registered from the next state. They change
            // in the same cycle as the state and never glitch.
            line_oe    <= (state_d inside {TX_START, TX_DATA, TX_STOP});
            line_out   <= (state_d == TX_START) ? 1'b0 :
                          (state_d == TX_DATA)  ? tx_sh_d[0] : 1'b1;
            rx_valid   <= pend_valid;
            rx_err     <= pend_err;
            if (pend_valid) rx_data <= rx_sh;
        end
    end

endmodule

// File: tb/tb_half_duplex_link.sv
// ---------------------------------------------------------------------------
// tb_half_duplex_link
//
// Bench for half_duplex_link with DATA_W=8, BIT_CYC=4, GUARD=2.
// The line is modelled as the buffer would present it. When the DUT drives,
// line_in echoes line_out. Otherwise line_in follows the far-end stimulus
// far_line.
//
// Cycle numbering: edge T is the accept edge of a transmit. "Cycle T+k" is
// the clock period that ends with edge T+k. Its value is sampled 1 time unit
// after edge T+k-1. Receive pulses are named by the edge that raises them.
// ---------------------------------------------------------------------------
module tb_half_duplex_link;

    localparam int DATA_W    = 8;
    localparam int BIT_CYC   = 4;
    localparam int GUARD     = 2;
    localparam int FRAME_CYC = (DATA_W + 2) * BIT_CYC;
    localparam int RX_LAT    = 2 + BIT_CYC / 2 + DATA_W * BIT_CYC + BIT_CYC + 1;

    logic              clk      = 1'b0;
    logic              rst      = 1'b1;
    logic              tx_valid = 1'b0;
    logic [DATA_W-1:0] tx_data  = '0;
    logic              tx_ready;
    logic              line_in;
    logic              line_out;
    logic              line_oe;
    logic              rx_valid;
    logic [DATA_W-1:0] rx_data;
    logic              rx_err;
    logic              busy;
    logic              far_line = 1'b1;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: payload of the last good received frame.
    logic [DATA_W-1:0] model_rx_data = '0;

    assign line_in = line_oe ? line_out : far_line;

    half_duplex_link #(
        .DATA_W (DATA_W),
        .BIT_CYC(BIT_CYC),
        .GUARD  (GUARD)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .tx_valid(tx_valid),
        .tx_data (tx_data),
        .tx_ready(tx_ready),
        .line_in (line_in),
        .line_out(line_out),
        .line_oe (line_oe),
        .rx_valid(rx_valid),
        .rx_data (rx_data),
        .rx_err  (rx_err),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic              is_tx;
        logic [DATA_W-1:0] data;
        logic              stop;
        logic [9:0]        exp_wave;  // bit k = line level during bit slot k
        logic              exp_v;
        logic              exp_e;
        logic [DATA_W-1:0] exp_d;
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, want %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Frame line levels from the format rule: start 0, data LSB first, stop.
    function automatic logic [9:0] frame_of(input logic [7:0] d, input logic stop);
        return {stop, d, 1'b0};
    endfunction

    // Offer a byte while the DUT is idle and return just after the accept edge T.
    task automatic start_tx(input logic [7:0] d);
        check1("tx_ready_before_accept", tx_ready, 1'b1);
        tx_valid = 1'b1;
        tx_data  = d;
        tick();
        tx_valid = 1'b0;
        tx_data  = ~d;
    endtask

    // Called just after accept edge T. Checks cycles T+1 .. T+43.
    task automatic check_tx_frame(input logic [9:0] wave);
        for (int j = 0; j < FRAME_CYC; j++) begin
            check1("tx_line_oe", line_oe, 1'b1);
            check1("tx_line_out", line_out, wave[j / BIT_CYC]);
            check1("tx_ready_during_tx", tx_ready, 1'b0);
            tick();
        end
        for (int g = 0; g < GUARD; g++) begin
            check1("turn_line_oe", line_oe, 1'b0);
            check1("turn_line_out", line_out, 1'b1);
            check1("turn_tx_ready", tx_ready, 1'b0);
            tick();
        end
        check1("tx_ready_after_turn", tx_ready, 1'b1);
        check1("busy_after_turn", busy, 1'b0);
    endtask

    // Drive one far-end frame. n counts edges from E0.
    task automatic do_rx(input logic [7:0] d, input logic stop,
                         input logic exp_v, input logic exp_e, input logic [7:0] exp_d);
        logic [9:0] wave;
        wave = frame_of(d, stop);
        for (int n = 0; n <= RX_LAT + 4; n++) begin
            far_line = (n < FRAME_CYC) ? wave[n / BIT_CYC] : 1'b1;
            tick();
            if (n == RX_LAT) begin
                check1("rx_valid_at_lat", rx_valid, exp_v);
                check1("rx_err_at_lat", rx_err, exp_e);
                check8("rx_data_at_lat", rx_data, exp_d);
            end else begin
                check1("rx_no_stray_pulse", rx_valid | rx_err, 1'b0);
            end
            if (n >= 2 && n < FRAME_CYC) check1("rx_tx_ready_low", tx_ready, 1'b0);
            if (n == FRAME_CYC && stop) check1("rx_tx_ready_back", tx_ready, 1'b1);
        end
        check1("rx_busy_end", busy, 1'b0);
    endtask

    initial begin
        int         acc;
        logic [9:0] wave;
        logic [7:0] d;
        int         op;

        vecs[0] = '{1'b1, 8'hA5, 1'b1, 10'b1101001010, 1'b0, 1'b0, 8'h00};
        vecs[1] = '{1'b0, 8'h3C, 1'b1, 10'b0,          1'b1, 1'b0, 8'h3C};
        vecs[2] = '{1'b0, 8'hC3, 1'b0, 10'b0,          1'b0, 1'b1, 8'h3C};
        vecs[3] = '{1'b1, 8'h00, 1'b1, 10'b1000000000, 1'b0, 1'b0, 8'h00};
        vecs[4] = '{1'b1, 8'hFF, 1'b1, 10'b1111111110, 1'b0, 1'b0, 8'h00};
        vecs[5] = '{1'b0, 8'h81, 1'b1, 10'b0,          1'b1, 1'b0, 8'h81};
        vecs[6] = '{1'b0, 8'h00, 1'b0, 10'b0,          1'b0, 1'b1, 8'h81};
        vecs[7] = '{1'b1, 8'h01, 1'b1, 10'b1000000010, 1'b0, 1'b0, 8'h00};

        // Reset state.
        repeat (3) tick();
        rst = 1'b0;
        check1("rst_line_oe", line_oe, 1'b0);
        check1("rst_line_out", line_out, 1'b1);
        check1("rst_tx_ready", tx_ready, 1'b1);
        check1("rst_busy", busy, 1'b0);
        check8("rst_rx_data", rx_data, 8'h00);
        for (int i = 0; i < 8; i++) begin
            tick();
            check1("idle_no_pulse", rx_valid | rx_err, 1'b0);
            check1("idle_line_oe", line_oe, 1'b0);
        end

        // Table-driven frames.
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].is_tx) begin
                start_tx(vecs[i].data);
                check_tx_frame(vecs[i].exp_wave);
            end else begin
                do_rx(vecs[i].data, vecs[i].stop, vecs[i].exp_v, vecs[i].exp_e, vecs[i].exp_d);
                if (vecs[i].exp_v) model_rx_data = vecs[i].exp_d;
            end
            tick();
        end

        // One-cycle low glitch: RX_START is entered, then aborts without a pulse.
        far_line = 1'b0;
        tick();
        far_line = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            tick();
            check1("glitch_no_pulse", rx_valid | rx_err, 1'b0);
            if (n == 2) check1("glitch_detected_busy", busy, 1'b1);
            if (n == 6) begin
                check1("glitch_idle_busy", busy, 1'b0);
                check1("glitch_idle_ready", tx_ready, 1'b1);
            end
        end
        tick();

        // tx_valid rises in the cycle in which rs first reads 0. The receive
        // completes first, then the pending byte is accepted at edge E0+41.
        wave = frame_of(8'h96, 1'b1);
        acc  = -1;
        for (int n = 0; n < 60 && acc < 0; n++) begin
            far_line = (n < FRAME_CYC) ? wave[n / BIT_CYC] : 1'b1;
            if (n == 2) begin
                tx_valid = 1'b1;
                tx_data  = 8'h5A;
            end
            if (tx_valid && tx_ready) acc = n;
            tick();
            if (n == RX_LAT) begin
                check1("hold_rx_valid", rx_valid, 1'b1);
                check8("hold_rx_data", rx_data, 8'h96);
            end
            if (acc == n) tx_valid = 1'b0;
        end
        check8("hold_accept_edge", 8'(acc), 8'(RX_LAT));
        tx_valid = 1'b0;
        far_line = 1'b1;
        if (acc >= 0) check_tx_frame(frame_of(8'h5A, 1'b1));
        model_rx_data = 8'h96;
        tick();

        // Randomized traffic against the model.
        for (int r = 0; r < 24; r++) begin
            op = int'($urandom_range(0, 3));
            d  = 8'($urandom);
            repeat ($urandom_range(0, 3)) tick();
            if (op <= 1) begin
                start_tx(d);
                check_tx_frame(frame_of(d, 1'b1));
            end else if (op == 2) begin
                do_rx(d, 1'b1, 1'b1, 1'b0, d);
                model_rx_data = d;
            end else begin
                do_rx(d, 1'b0, 1'b0, 1'b1, model_rx_data);
            end
        end
        tick();

        // Reset in the middle of a transmit drops line_oe without a clock edge.
        start_tx(8'h33);
        repeat (9) tick();
        check1("pre_rst_line_oe", line_oe, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check1("async_rst_line_oe", line_oe, 1'b0);
        check1("async_rst_line_out", line_out, 1'b1);
        check1("async_rst_busy", busy, 1'b0);
        #1;
        rst = 1'b0;
        tick();
        check1("post_rst_tx_ready", tx_ready, 1'b1);
        check1("post_rst_line_oe", line_oe, 1'b0);
        check8("post_rst_rx_data", rx_data, 8'h00);
        for (int i = 0; i < 6; i++) begin
            tick();
            check1("post_rst_no_pulse", rx_valid | rx_err, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
